// File: rtl/slc3_mem_responder.sv
// slc3_mem_responder
// Memory-side responder for the SLC-3 core bus. On-chip RAM plus one
// memory-mapped I/O word: a read of it returns the synchronised switches and
// a write to it loads the hex-display register. After reset the RAM is
// zero-filled before any core access is accepted. Reads return after a fixed
// READ_LATENCY edges through an in-order pipeline.
//
//   state    | meaning
//   ---------+--------------------------------------------------------
//   ST_CLEAR | zero-filling RAM one word per cycle, core requests ignored
//   ST_READY | RAM initialised, one core request accepted per edge
module slc3_mem_responder #(
  parameter int          ADDR_BITS    = 10,
  parameter int          READ_LATENCY = 2,
  parameter logic [15:0] IO_ADDR      = 16'hFFFF
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [15:0] mem_addr,
  input  logic [15:0] mem_wdata,
  input  logic        mem_mem_ena,
  input  logic        mem_wr_ena,
  output logic [15:0] mem_rdata,
  output logic        mem_rvalid,
  input  logic [15:0] sw_i,
  output logic [15:0] hex_o,
  output logic        init_done
);

  localparam int DEPTH = 1 << ADDR_BITS;

  typedef enum logic {
    ST_CLEAR = 1'b0,
    ST_READY = 1'b1
  } state_t;

  state_t                 state_q, state_d;
  logic [ADDR_BITS-1:0]   clr_cnt_q, clr_cnt_d;
  logic                   init_done_q;

  logic [15:0]            sw_meta_q, sw_sync_q;
  logic [15:0]            hex_q, hex_d;

  logic [15:0]            ram [DEPTH];
  logic                   ram_we;
  logic [ADDR_BITS-1:0]   ram_waddr;
  logic [15:0]            ram_wdata;

  logic                   addr_is_io;
  logic                   addr_in_ram;
  logic [ADDR_BITS-1:0]   ram_idx;
  logic                   rd_req;
  logic [15:0]            rd_data;

  logic [READ_LATENCY-1:0] pipe_vld_q;
  logic [15:0]             pipe_data_q [READ_LATENCY];
  logic [15:0]             rdata_q;
  logic                    rvalid_q;

  // Address decode; the I/O word wins over the RAM range check.
  assign addr_is_io  = (mem_addr == IO_ADDR);
  assign addr_in_ram = ((mem_addr >> ADDR_BITS) == 16'd0);
  assign ram_idx     = mem_addr[ADDR_BITS-1:0];

  // FSM state, clear counter and init flag.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q     <= ST_CLEAR;
      clr_cnt_q   <= '0;
      init_done_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      clr_cnt_q   <= clr_cnt_d;
      init_done_q <= (state_d == ST_READY);
    end
  end

  // Next state, RAM write port steering, hex load and read issue.
  always_comb begin
    state_d   = state_q;
    clr_cnt_d = clr_cnt_q;
    ram_we    = 1'b0;
    ram_waddr = clr_cnt_q;
    ram_wdata = 16'h0000;
    hex_d     = hex_q;
    rd_req    = 1'b0;
    case (state_q)
      ST_CLEAR: begin
        ram_we    = 1'b1;
        clr_cnt_d = clr_cnt_q + 1'b1;
        if (clr_cnt_q == '1) begin
          state_d = ST_READY;
        end
      end
      ST_READY: begin
        if (mem_mem_ena) begin
          if (mem_wr_ena) begin
            if (addr_is_io) begin
              hex_d = mem_wdata;
            end else if (addr_in_ram) begin
              ram_we    = 1'b1;
              ram_waddr = ram_idx;
              ram_wdata = mem_wdata;
            end
          end else begin
            rd_req = 1'b1;
          end
        end
      end
      default: begin
        state_d   = ST_CLEAR;
        clr_cnt_d = '0;
      end
    endcase
  end

  // Read source: switches for the I/O word, RAM in range, zero otherwise.
  // Captured at the sampling edge so later writes cannot disturb it.
  always_comb begin
    rd_data = 16'h0000;
    if (addr_is_io) begin
      rd_data = sw_sync_q;
    end else if (addr_in_ram) begin
      rd_data = ram[ram_idx];
    end
  end

  // RAM storage; contents deliberately survive reset.
  always_ff @(posedge clk) begin
    if (ram_we) begin
      ram[ram_waddr] <= ram_wdata;
    end
  end

  // Two-flop switch synchroniser, free-running in every state.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      sw_meta_q <= 16'h0000;
      sw_sync_q <= 16'h0000;
    end else begin
      sw_meta_q <= sw_i;
      sw_sync_q <= sw_meta_q;
    end
  end

  // Hex-display register.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      hex_q <= 16'h0000;
    end else begin
      hex_q <= hex_d;
    end
  end

  // Read pipeline: stage 0 loads on the sampling edge, the output register
  // loads READ_LATENCY edges after it. Reset drops anything in flight.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      pipe_vld_q <= '0;
      for (int i = 0; i < READ_LATENCY; i++) begin
        pipe_data_q[i] <= 16'h0000;
      end
    end else begin
      pipe_vld_q[0]  <= rd_req;
      pipe_data_q[0] <= rd_data;
      for (int i = 1; i < READ_LATENCY; i++) begin
        pipe_vld_q[i]  <= pipe_vld_q[i-1];
        pipe_data_q[i] <= pipe_data_q[i-1];
      end
    end
  end

  // Return register: data holds between results, valid is a one-cycle pulse.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      rdata_q  <= 16'h0000;
      rvalid_q <= 1'b0;
    end else begin
      rvalid_q <= pipe_vld_q[READ_LATENCY-1];
      if (pipe_vld_q[READ_LATENCY-1]) begin
        rdata_q <= pipe_data_q[READ_LATENCY-1];
      end
    end
  end

  assign mem_rdata  = rdata_q;
  assign mem_rvalid = rvalid_q;
  assign hex_o      = hex_q;
  assign init_done  = init_done_q;

endmodule

// File: tb/tb_slc3_mem_responder.sv
// Directed bench for slc3_mem_responder with a 16-word RAM and 2-edge reads.
module tb_slc3_mem_responder;

  logic        clk;
  logic        reset;
  logic [15:0] mem_addr;
  logic [15:0] mem_wdata;
  logic        mem_mem_ena;
  logic        mem_wr_ena;
  logic [15:0] mem_rdata;
  logic        mem_rvalid;
  logic [15:0] sw_i;
  logic [15:0] hex_o;
  logic        init_done;

  int n_vec;
  int n_err;

  slc3_mem_responder #(
    .ADDR_BITS   (4),
    .READ_LATENCY(2),
    .IO_ADDR     (16'hFFFF)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .mem_addr   (mem_addr),
    .mem_wdata  (mem_wdata),
    .mem_mem_ena(mem_mem_ena),
    .mem_wr_ena (mem_wr_ena),
    .mem_rdata  (mem_rdata),
    .mem_rvalid (mem_rvalid),
    .sw_i       (sw_i),
    .hex_o      (hex_o),
    .init_done  (init_done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic step;
    @(posedge clk);
    #1;
  endtask

  task automatic idle;
    mem_mem_ena = 1'b0;
    mem_wr_ena  = 1'b0;
    mem_addr    = 16'h0000;
    mem_wdata   = 16'h0000;
  endtask

  task automatic do_write(input logic [15:0] addr, input logic [15:0] data);
    mem_mem_ena = 1'b1;
    mem_wr_ena  = 1'b1;
    mem_addr    = addr;
    mem_wdata   = data;
    step;
    idle;
  endtask

  task automatic do_read(input logic [15:0] addr, input logic [15:0] exp, input string name);
    mem_mem_ena = 1'b1;
    mem_wr_ena  = 1'b0;
    mem_addr    = addr;
    step;
    idle;
    step;
    n_vec++;
    if (mem_rvalid !== 1'b0) begin
      n_err++;
      $display("FAIL %s early_rvalid: got %b want 0", name, mem_rvalid);
    end
    step;
    n_vec++;
    if (mem_rvalid !== 1'b1 || mem_rdata !== exp) begin
      n_err++;
      $display("FAIL %s read @%h: got rvalid=%b data=%h want rvalid=1 data=%h",
               name, addr, mem_rvalid, mem_rdata, exp);
    end
  endtask

  // Steps until init_done rises; returns the edge count (0 on timeout) and
  // whether mem_rvalid was seen high. Injects core requests that must be ignored.
  task automatic run_clear(input bit inject, output int first_k, output bit saw_rvalid);
    first_k    = 0;
    saw_rvalid = 1'b0;
    for (int k = 1; k <= 64; k++) begin
      step;
      if (mem_rvalid === 1'b1) saw_rvalid = 1'b1;
      if (init_done === 1'b1 && first_k == 0) first_k = k;
      if (inject) begin
        case (k)
          2: begin mem_mem_ena = 1'b1; mem_wr_ena = 1'b1; mem_addr = 16'h0001; mem_wdata = 16'h5555; end
          3: begin mem_mem_ena = 1'b1; mem_wr_ena = 1'b1; mem_addr = 16'hFFFF; mem_wdata = 16'hABCD; end
          4: begin mem_mem_ena = 1'b1; mem_wr_ena = 1'b0; mem_addr = 16'h0000; end
          default: idle;
        endcase
      end
      if (first_k != 0 && k >= first_k + 3) break;
    end
  endtask

  task automatic test_reset;
    int  first_k;
    bit  saw;
    reset = 1'b0;
    idle;
    sw_i = 16'h0000;
    repeat (3) step;
    n_vec++;
    if (mem_rdata !== 16'h0000 || mem_rvalid !== 1'b0 || hex_o !== 16'h0000 || init_done !== 1'b0) begin
      n_err++;
      $display("FAIL reset_state: got rdata=%h rvalid=%b hex=%h init=%b want 0000 0 0000 0",
               mem_rdata, mem_rvalid, hex_o, init_done);
    end
    reset = 1'b1;
    run_clear(1'b1, first_k, saw);
    idle;
    n_vec++;
    if (first_k != 16) begin
      n_err++;
      $display("FAIL clear_length: got init_done after %0d edges want 16", first_k);
    end
    n_vec++;
    if (saw) begin
      n_err++;
      $display("FAIL clear_gating_rvalid: got rvalid pulse during clear want none");
    end
    n_vec++;
    if (hex_o !== 16'h0000) begin
      n_err++;
      $display("FAIL clear_gating_hex: got %h want 0000", hex_o);
    end
  endtask

  task automatic test_clear_contents;
    for (int a = 0; a < 16; a++) begin
      do_read(16'(a), 16'h0000, "clear_contents");
    end
  endtask

  task automatic test_write_read;
    do_write(16'h0003, 16'hBEEF);
    do_read(16'h0003, 16'hBEEF, "wr_rd");
    step;
    n_vec++;
    if (mem_rvalid !== 1'b0 || mem_rdata !== 16'hBEEF) begin
      n_err++;
      $display("FAIL wr_rd_hold: got rvalid=%b data=%h want 0 BEEF", mem_rvalid, mem_rdata);
    end
  endtask

  task automatic test_pipelined;
    logic [15:0] exp_q [3];
    exp_q[0] = 16'h1111;
    exp_q[1] = 16'h2222;
    exp_q[2] = 16'h3333;
    do_write(16'h0001, 16'h1111);
    do_write(16'h0002, 16'h2222);
    do_write(16'h0003, 16'h3333);
    mem_mem_ena = 1'b1;
    mem_wr_ena  = 1'b0;
    mem_addr    = 16'h0001;
    step;
    mem_addr    = 16'h0002;
    step;
    mem_addr    = 16'h0003;
    for (int i = 0; i < 3; i++) begin
      step;
      idle;
      n_vec++;
      if (mem_rvalid !== 1'b1 || mem_rdata !== exp_q[i]) begin
        n_err++;
        $display("FAIL pipelined[%0d]: got rvalid=%b data=%h want 1 %h", i, mem_rvalid, mem_rdata, exp_q[i]);
      end
    end
    step;
    n_vec++;
    if (mem_rvalid !== 1'b0 || mem_rdata !== 16'h3333) begin
      n_err++;
      $display("FAIL pipelined_end: got rvalid=%b data=%h want 0 3333", mem_rvalid, mem_rdata);
    end
  endtask

  task automatic test_write_during_read;
    mem_mem_ena = 1'b1;
    mem_wr_ena  = 1'b0;
    mem_addr    = 16'h0001;
    step;
    mem_wr_ena  = 1'b1;
    mem_wdata   = 16'h9999;
    step;
    idle;
    step;
    n_vec++;
    if (mem_rvalid !== 1'b1 || mem_rdata !== 16'h1111) begin
      n_err++;
      $display("FAIL inflight_write: got rvalid=%b data=%h want 1 1111", mem_rvalid, mem_rdata);
    end
    do_read(16'h0001, 16'h9999, "after_inflight_write");
  endtask

  task automatic test_io;
    sw_i = 16'h00A5;
    repeat (3) step;
    do_read(16'hFFFF, 16'h00A5, "io_sw_a5");
    sw_i = 16'h5A3C;
    repeat (3) step;
    do_read(16'hFFFF, 16'h5A3C, "io_sw_5a3c");
    do_write(16'hFFFF, 16'h1234);
    n_vec++;
    if (hex_o !== 16'h1234 || mem_rvalid !== 1'b0) begin
      n_err++;
      $display("FAIL io_hex_write: got hex=%h rvalid=%b want 1234 0", hex_o, mem_rvalid);
    end
    step;
    step;
    n_vec++;
    if (mem_rvalid !== 1'b0) begin
      n_err++;
      $display("FAIL io_write_rvalid: got %b want 0", mem_rvalid);
    end
  endtask

  task automatic test_out_of_range;
    do_read(16'h4000, 16'h0000, "oor_4000");
    do_write(16'h000F, 16'hCAFE);
    do_read(16'h000F, 16'hCAFE, "top_word");
    do_write(16'h0010, 16'h7777);
    do_read(16'h0000, 16'h0000, "oor_no_alias");
    do_read(16'h0010, 16'h0000, "oor_0010");
    n_vec++;
    if (hex_o !== 16'h1234) begin
      n_err++;
      $display("FAIL oor_hex_untouched: got %h want 1234", hex_o);
    end
  endtask

  task automatic test_reset_mid_read;
    int first_k;
    bit saw;
    bit saw_hold;
    saw_hold = 1'b0;
    mem_mem_ena = 1'b1;
    mem_wr_ena  = 1'b0;
    mem_addr    = 16'h0003;
    step;
    idle;
    reset = 1'b0;
    #1;
    n_vec++;
    if (mem_rdata !== 16'h0000 || mem_rvalid !== 1'b0 || init_done !== 1'b0 || hex_o !== 16'h0000) begin
      n_err++;
      $display("FAIL midread_reset_state: got rdata=%h rvalid=%b init=%b hex=%h want 0000 0 0 0000",
               mem_rdata, mem_rvalid, init_done, hex_o);
    end
    repeat (3) begin
      step;
      if (mem_rvalid === 1'b1) saw_hold = 1'b1;
    end
    reset = 1'b1;
    run_clear(1'b0, first_k, saw);
    n_vec++;
    if (saw || saw_hold) begin
      n_err++;
      $display("FAIL midread_rvalid: got rvalid pulse want none");
    end
    n_vec++;
    if (first_k != 16) begin
      n_err++;
      $display("FAIL midread_reclear: got init_done after %0d edges want 16", first_k);
    end
    do_read(16'h0003, 16'h0000, "after_reclear");
  endtask

  initial begin
    n_vec = 0;
    n_err = 0;
    test_reset;
    test_clear_contents;
    test_write_read;
    test_pipelined;
    test_write_during_read;
    test_io;
    test_out_of_range;
    test_reset_mid_read;
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
